// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit SDRAM controller channel between NUM_REQ requesters.
// Optional statistics counters are built only when SDRAM_ARB_STATS_EN is defined.
module sdram_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int WAIT_W         = 10
) (
    input  logic                    clk,
    input  logic                    init_n,
    input  logic [NUM_REQ-1:0]      rq_req,
    input  logic [NUM_REQ*27-1:0]   rq_addr,
    input  logic [NUM_REQ*32-1:0]   rq_din,
    input  logic [NUM_REQ*4-1:0]    rq_be,
    input  logic [NUM_REQ-1:0]      rq_rnw,
    output logic [NUM_REQ-1:0]      rq_ack,
    output logic                    rq_err,
    output logic [31:0]             rq_dout,
    output logic [26:0]             ram_addr,
    output logic [31:0]             ram_din,
    output logic [3:0]              ram_be,
    output logic                    ram_rnw,
    output logic                    ram_req,
    input  logic [31:0]             ram_dout,
    input  logic                    ram_ready,
    output logic                    busy,
    output logic [31:0]             stat_busy_cycles,
    output logic [7:0]              stat_timeouts
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [26:0]        ram_addr_reg;
    logic [31:0]        ram_din_reg;
    logic [3:0]         ram_be_reg;
    logic               ram_rnw_reg;
    logic               ram_req_reg;
    logic [NUM_REQ-1:0] rq_ack_reg;
    logic               rq_err_reg;
    logic [31:0]        rq_dout_reg;

    logic [26:0]        addr_arr [NUM_REQ];
    logic [31:0]        din_arr  [NUM_REQ];
    logic [3:0]         be_arr   [NUM_REQ];

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand_int;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               accept_ready;
    logic               timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = rq_addr[27*gi +: 27];
            assign din_arr[gi]  = rq_din[32*gi +: 32];
            assign be_arr[gi]   = rq_be[4*gi +: 4];
        end
    endgenerate

    // Search starts one past the last grantee so every requester is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_int    = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_int = int'(grant_reg) + k;
            if (cand_int >= NUM_REQ) begin
                cand_int = cand_int - NUM_REQ;
            end
            cand_idx = cand_int[IDX_W-1:0];
            if (!grant_found && rq_req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_reg] = 1'b1;
    end

    // A ready pulse is honoured in ISSUE as well as WAIT; it always beats the timeout.
    assign accept_ready = ram_ready && ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT));
    assign timeout_hit  = (state_reg == ST_WAIT) && !ram_ready &&
                          (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= IDX_W'(NUM_REQ - 1);
            wait_cnt_reg <= '0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_be_reg   <= '0;
            ram_rnw_reg  <= 1'b0;
            ram_req_reg  <= 1'b0;
            rq_ack_reg   <= '0;
            rq_err_reg   <= 1'b0;
            rq_dout_reg  <= '0;
        end else begin
            ram_req_reg <= 1'b0;
            rq_ack_reg  <= '0;
            rq_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_reg    <= grant_idx;
                        ram_addr_reg <= addr_arr[grant_idx];
                        ram_din_reg  <= din_arr[grant_idx];
                        ram_be_reg   <= be_arr[grant_idx];
                        ram_rnw_reg  <= rq_rnw[grant_idx];
                        ram_req_reg  <= 1'b1;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                    if (accept_ready) begin
                        if (ram_rnw_reg) begin
                            rq_dout_reg <= ram_dout;
                        end
                        rq_ack_reg <= grant_onehot;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (accept_ready) begin
                        if (ram_rnw_reg) begin
                            rq_dout_reg <= ram_dout;
                        end
                        rq_ack_reg <= grant_onehot;
                        state_reg  <= ST_DONE;
                    end else if (timeout_hit) begin
                        rq_ack_reg <= grant_onehot;
                        rq_err_reg <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_be   = ram_be_reg;
    assign ram_rnw  = ram_rnw_reg;
    assign ram_req  = ram_req_reg;
    assign rq_ack   = rq_ack_reg;
    assign rq_err   = rq_err_reg;
    assign rq_dout  = rq_dout_reg;

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] busy_cnt_reg;
    logic [7:0]  timeout_cnt_reg;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            busy_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            if (busy) begin
                busy_cnt_reg <= busy_cnt_reg + 32'd1;
            end
            if (timeout_hit && (timeout_cnt_reg != 8'hFF)) begin
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
        end
    end

    assign stat_busy_cycles = busy_cnt_reg;
    assign stat_timeouts    = timeout_cnt_reg;
`else
    assign stat_busy_cycles = 32'd0;
    assign stat_timeouts    = 8'd0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a controller model answers ram_req pulses,
// requesters hold rq_req until acked, and every issue/ack is checked against queued expectations.
module tb_sdram_port_arbiter;

    localparam int NR = 4;
    localparam int TO = 1023;

    logic              clk = 1'b0;
    logic              init_n = 1'b0;
    logic [NR-1:0]     rq_req;
    logic [NR*27-1:0]  rq_addr;
    logic [NR*32-1:0]  rq_din;
    logic [NR*4-1:0]   rq_be;
    logic [NR-1:0]     rq_rnw;
    logic [NR-1:0]     rq_ack;
    logic              rq_err;
    logic [31:0]       rq_dout;
    logic [26:0]       ram_addr;
    logic [31:0]       ram_din;
    logic [3:0]        ram_be;
    logic              ram_rnw;
    logic              ram_req;
    logic [31:0]       ram_dout = 32'd0;
    logic              ram_ready = 1'b0;
    logic              busy;
    logic [31:0]       stat_busy_cycles;
    logic [7:0]        stat_timeouts;

    typedef struct {
        int          idx;
        logic [26:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        rnw;
        logic        err;
        logic [31:0] dout;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          want_cnt [NR] = '{0, 0, 0, 0};
    int          done_cnt [NR] = '{0, 0, 0, 0};
    logic [26:0] base_addr [NR] = '{27'h010, 27'h020, 27'h030, 27'h040};
    logic [31:0] base_din  [NR] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    logic [3:0]  base_be   [NR] = '{4'hF, 4'h1, 4'h3, 4'h8};
    logic        base_rnw  [NR] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int          ready_delay = 3;
    logic [31:0] model_dout = 32'd0;

    sdram_port_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .WAIT_W(10)) dut (
        .clk              (clk),
        .init_n           (init_n),
        .rq_req           (rq_req),
        .rq_addr          (rq_addr),
        .rq_din           (rq_din),
        .rq_be            (rq_be),
        .rq_rnw           (rq_rnw),
        .rq_ack           (rq_ack),
        .rq_err           (rq_err),
        .rq_dout          (rq_dout),
        .ram_addr         (ram_addr),
        .ram_din          (ram_din),
        .ram_be           (ram_be),
        .ram_rnw          (ram_rnw),
        .ram_req          (ram_req),
        .ram_dout         (ram_dout),
        .ram_ready        (ram_ready),
        .busy             (busy),
        .stat_busy_cycles (stat_busy_cycles),
        .stat_timeouts    (stat_timeouts)
    );

    always #5 clk = ~clk;

    always_comb begin
        rq_req  = '0;
        rq_addr = '0;
        rq_din  = '0;
        rq_be   = '0;
        rq_rnw  = '0;
        for (int i = 0; i < NR; i++) begin
            rq_req[i]          = (want_cnt[i] > done_cnt[i]);
            rq_addr[27*i +: 27] = base_addr[i];
            rq_din[32*i +: 32]  = base_din[i];
            rq_be[4*i +: 4]     = base_be[i];
            rq_rnw[i]           = base_rnw[i];
        end
    end

    function automatic logic [31:0] rd_data(logic [26:0] a);
        return 32'hDEADBFEF ^ {5'b0, a};
    endfunction

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_txn(int i, logic err, int lat);
        exp_t e;
        e.idx  = i;
        e.addr = base_addr[i];
        e.din  = base_din[i];
        e.be   = base_be[i];
        e.rnw  = base_rnw[i];
        e.err  = err;
        if (!err && base_rnw[i]) begin
            model_dout = rd_data(base_addr[i]);
        end
        e.dout = model_dout;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    // Controller model, issue checker and ack scoreboard, all evaluated mid-cycle.
    initial begin
        int   cyc = 0;
        int   last_req = -1;
        int   rcnt = 0;
        int   rdelay = 0;
        bit   ractive = 1'b0;
        bit   prev_req = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!init_n) begin
                ram_ready = 1'b0;
                ractive   = 1'b0;
                prev_req  = 1'b0;
                last_req  = -1;
                continue;
            end
            ram_ready = 1'b0;
            ram_dout  = $urandom;
            if (ram_req) begin
                check_val("req_one_cycle", 32'(prev_req), 32'd0);
                if (last_req >= 0) begin
                    check_val("req_gap_ge4", 32'((cyc - last_req) >= 4), 32'd1);
                end
                if (exp_q.size() == 0) begin
                    check_val("unexpected_req", 32'd1, 32'd0);
                end else begin
                    check_val("ram_addr", 32'(ram_addr), 32'(exp_q[0].addr));
                    check_val("ram_rnw", 32'(ram_rnw), 32'(exp_q[0].rnw));
                    if (!exp_q[0].rnw) begin
                        check_val("ram_din", ram_din, exp_q[0].din);
                        check_val("ram_be", 32'(ram_be), 32'(exp_q[0].be));
                    end
                end
                last_req = cyc;
                ractive  = 1'b1;
                rcnt     = 0;
                rdelay   = ready_delay;
            end
            prev_req = ram_req;
            if (ractive) begin
                if (rcnt == rdelay) begin
                    ram_ready = 1'b1;
                    ram_dout  = rd_data(ram_addr);
                    ractive   = 1'b0;
                end else begin
                    rcnt++;
                end
            end
            if (rq_ack != '0) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_ack", 32'(rq_ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("ack_onehot", 32'(rq_ack), 32'(1) << e.idx);
                    check_val("ack_err", 32'(rq_err), 32'(e.err));
                    check_val("ack_dout", rq_dout, e.dout);
                    check_val("ack_latency", 32'(cyc - last_req), 32'(e.lat));
                    $display("txn req%0d rnw=%0d addr=%07h err=%0d dout=%08h lat=%0d",
                             e.idx, e.rnw, e.addr, rq_err, rq_dout, cyc - last_req);
                end
                for (int i = 0; i < NR; i++) begin
                    if (rq_ack[i]) begin
                        done_cnt[i]++;
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check_val("rst_ack", 32'(rq_ack), 32'd0);
        check_val("rst_err", 32'(rq_err), 32'd0);
        check_val("rst_dout", rq_dout, 32'd0);
        check_val("rst_ram_req", 32'(ram_req), 32'd0);
        check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_stat_busy", stat_busy_cycles, 32'd0);
        check_val("rst_stat_to", 32'(stat_timeouts), 32'd0);
        init_n = 1'b1;
        repeat (2) tick();

        // All four requesting: grant order must be 0,1,2,3,0,1.
        ready_delay = 3;
        want_cnt[0] = done_cnt[0] + 2;
        want_cnt[1] = done_cnt[1] + 2;
        want_cnt[2] = done_cnt[2] + 1;
        want_cnt[3] = done_cnt[3] + 1;
        push_txn(0, 1'b0, 4);
        push_txn(1, 1'b0, 4);
        push_txn(2, 1'b0, 4);
        push_txn(3, 1'b0, 4);
        push_txn(0, 1'b0, 4);
        push_txn(1, 1'b0, 4);
        wait_drain(300);

        // Single read from requester 0, ready 5 cycles after ram_req.
        base_addr[0] = 27'h0000100;
        base_rnw[0]  = 1'b1;
        ready_delay  = 5;
        push_txn(0, 1'b0, 6);
        want_cnt[0]++;
        @(negedge clk);
        #1;
        check_val("req_not_yet", 32'(ram_req), 32'd0);
        @(negedge clk);
        #1;
        check_val("req_issue_latency", 32'(ram_req), 32'd1);
        check_val("busy_in_issue", 32'(busy), 32'd1);
        wait_drain(100);
        check_val("read_dout", rq_dout, 32'hDEADBEEF);

        // Write from requester 2: data/be latched, rq_dout untouched.
        base_addr[2] = 27'h0000200;
        base_din[2]  = 32'h12345678;
        base_be[2]   = 4'b0011;
        base_rnw[2]  = 1'b0;
        ready_delay  = 2;
        push_txn(2, 1'b0, 3);
        want_cnt[2]++;
        wait_drain(100);
        check_val("write_dout_kept", rq_dout, 32'hDEADBEEF);
        check_val("write_din_held", ram_din, 32'h12345678);
        check_val("write_be_held", 32'(ram_be), 32'h3);
        check_val("write_rnw_held", 32'(ram_rnw), 32'd0);

        // No ready in time: timeout completion, then a stray ready that must be ignored.
        base_addr[3] = 27'h0000300;
        base_rnw[3]  = 1'b1;
        ready_delay  = 1030;
        push_txn(3, 1'b1, TO + 1);
        want_cnt[3]++;
        wait_drain(1200);
        repeat (20) tick();
        check_val("timeout_dout_kept", rq_dout, 32'hDEADBEEF);
        check_val("timeout_idle", 32'(busy), 32'd0);
`ifdef SDRAM_ARB_STATS_EN
        check_val("stat_timeouts", 32'(stat_timeouts), 32'd1);
        check_val("stat_busy_nonzero", 32'(stat_busy_cycles != 0), 32'd1);
`else
        check_val("stat_timeouts_off", 32'(stat_timeouts), 32'd0);
        check_val("stat_busy_off", stat_busy_cycles, 32'd0);
`endif

        // Ready on the very cycle the wait expires: ready wins.
        base_addr[1] = 27'h0000400;
        base_rnw[1]  = 1'b1;
        ready_delay  = TO;
        push_txn(1, 1'b0, TO + 1);
        want_cnt[1]++;
        wait_drain(1200);
        check_val("coincide_dout", rq_dout, rd_data(27'h0000400));

        // Reset in WAIT abandons the transaction; requester 0 wins first afterwards.
        base_addr[1] = 27'h0000500;
        ready_delay  = -1;
        push_txn(1, 1'b1, 0);
        want_cnt[1]++;
        repeat (8) tick();
        check_val("busy_before_reset", 32'(busy), 32'd1);
        init_n = 1'b0;
        #1;
        exp_q.delete();
        model_dout = 32'd0;
        check_val("mid_rst_ack", 32'(rq_ack), 32'd0);
        check_val("mid_rst_dout", rq_dout, 32'd0);
        check_val("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        check_val("mid_rst_ram_din", ram_din, 32'd0);
        check_val("mid_rst_ram_be", 32'(ram_be), 32'd0);
        check_val("mid_rst_ram_rnw", 32'(ram_rnw), 32'd0);
        check_val("mid_rst_ram_req", 32'(ram_req), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        ready_delay = 2;
        want_cnt[0]++;
        want_cnt[2]++;
        want_cnt[3]++;
        push_txn(0, 1'b0, 3);
        push_txn(1, 1'b0, 3);
        push_txn(2, 1'b0, 3);
        push_txn(3, 1'b0, 3);
        init_n = 1'b1;
        wait_drain(300);
        check_val("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
